// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the burst controller in front of the 64K x 8 memory.
// Wrapping bursts are selected at build time with the BURST_WRAP_EN macro.
package mem_burst_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

endpackage

// File: rtl/mem_rd_buf.sv
// Two-entry read return FIFO; absorbs the memory's one-cycle read latency.
// A push and a pop in the same cycle leave the count unchanged.
module mem_rd_buf
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst access controller driving the 64K x 8 memory: one command at a time, write beats
// in on a valid/ready stream, read beats out through a 2-entry buffer. Macro: BURST_WRAP_EN.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_mem_write,
  output logic              o_mem_read,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out
);

`ifdef BURST_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] WinMask = ADDR_W'((1 << WRAP_W) - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [LEN_W-1:0]  r_remain;
  logic              r_inflight;
  logic              w_issue;
  logic              w_pop;
  logic              w_buf_valid;
  logic [1:0]        w_buf_count;
  logic [1:0]        w_occ;

  assign w_addr_inc = r_addr + ADDR_W'(1);
  // Wrapping keeps the upper bits fixed so the burst stays in its aligned window.
  assign w_addr_nxt = WrapEn ? ((r_addr & ~WinMask) | (w_addr_inc & WinMask)) : w_addr_inc;

  assign w_pop = i_rd_ready && w_buf_valid;
  assign w_occ = w_buf_count + {1'b0, r_inflight};

  always_comb begin
    w_state_nxt   = r_state;
    o_cmd_ready   = 1'b0;
    o_wr_ready    = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_addr    = '0;
    o_mem_data_in = '0;
    w_issue       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_cmd_ready = rst_n;
        if (i_cmd_valid) begin
          case (i_cmd_op)
            OP_WRITE: w_state_nxt = StWrite;
            OP_READ:  w_state_nxt = StRead;
          endcase
        end
      end
      StWrite: begin
        o_wr_ready    = 1'b1;
        o_mem_write   = i_wr_valid;
        o_mem_addr    = r_addr;
        o_mem_data_in = i_wr_data;
        if (i_wr_valid && (r_remain == '0)) begin
          w_state_nxt = StIdle;
        end
      end
      StRead: begin
        o_mem_addr = r_addr;
        // A same-cycle pop frees a slot, which keeps reads at one beat per cycle.
        w_issue    = (w_occ < 2'd2) || w_pop;
        o_mem_read = w_issue;
        if (w_issue && (r_remain == '0)) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (!r_inflight && (w_buf_count == 2'd0)) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if ((r_state == StIdle) && i_cmd_valid) begin
        r_addr   <= i_cmd_addr;
        r_remain <= i_cmd_len;
      end else if (((r_state == StWrite) && i_wr_valid) || w_issue) begin
        r_addr   <= w_addr_nxt;
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  assign o_busy = (r_state != StIdle);

  mem_rd_buf #(
    .DATA_W (DATA_W)
  ) u_rd_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (i_mem_data_out),
    .i_pop       (w_pop),
    .o_valid     (w_buf_valid),
    .o_data      (o_rd_data),
    .o_count     (w_buf_count)
  );

  assign o_rd_valid = w_buf_valid;

endmodule
